// File: rtl/booth_mult_32_pkg.sv
// Shared multdiv definitions: FSM state encoding and iteration bound.
// Used by the Booth multiplier and intended for reuse by the divider.
package booth_mult_32_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  // Counter value seen on the final (32nd) iteration edge.
  localparam logic [4:0] ITER_LAST = 5'd31;

endpackage

// File: rtl/counter_32.sv
// 5-bit iteration counter (0..31, wraps).
// Ports:
//   clk   - clock, posedge
//   en    - increment enable
//   rst   - synchronous active-high clear (wins over en)
//   count - current count
module counter_32 (
  input  logic       clk,
  input  logic       en,
  input  logic       rst,
  output logic [4:0] count
);

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 5'd0;
    end else if (en) begin
      count <= count + 5'd1;
    end
  end

endmodule

// File: rtl/booth_mult_32.sv
// Sequential signed 32x32 radix-2 Booth multiplier.
// One start pulse in IDLE launches 32 iterations (RUN), then a one-cycle DONE
// presents the low 32 product bits and a signed-overflow flag.
// Ports:
//   clk, rst     - clock and synchronous active-high reset
//   start        - request, honoured only in IDLE
//   multiplicand - signed M, captured on accept
//   multiplier   - signed Q, captured on accept
//   busy         - high while iterating
//   result_rdy   - one-cycle pulse, result/overflow valid
//   result       - low 32 bits of the 64-bit product (held until next DONE)
//   overflow     - product does not fit in 32-bit signed (held likewise)
module booth_mult_32
  import booth_mult_32_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] multiplicand,
  input  logic [WIDTH-1:0] multiplier,
  output logic             busy,
  output logic             result_rdy,
  output logic [WIDTH-1:0] result,
  output logic             overflow
);

  // The 5-bit iteration counter only sequences exactly 32 iterations.
  if (WIDTH != 32) begin : g_bad_width
    $error("booth_mult_32: WIDTH must be 32");
  end

  logic [1:0]         state;
  logic [WIDTH:0]     m;          // sign-extended multiplicand
  logic [2*WIDTH+1:0] p;          // {acc[WIDTH:0], Q, booth bit}
  logic [4:0]         count;
  logic               accept;
  logic [WIDTH:0]     acc;
  logic [WIDTH:0]     acc_nxt;
  logic [2*WIDTH+1:0] p_shift;
  logic               ovf_nxt;

  assign accept = (state == IDLE) && start;
  assign busy   = (state == RUN);

  counter_32 u_counter (
    .clk   (clk),
    .en    (state == RUN),
    .rst   (rst | accept),
    .count (count)
  );

  // One Booth step: conditional add/sub into the 33-bit accumulator, then
  // arithmetic shift right of the whole product register.
  always_comb begin
    acc     = p[2*WIDTH+1:WIDTH+1];
    acc_nxt = acc;
    unique case (p[1:0])
      2'b01:   acc_nxt = acc + m;
      2'b10:   acc_nxt = acc - m;
      default: acc_nxt = acc;
    endcase
    p_shift = {acc_nxt[WIDTH], acc_nxt, p[WIDTH:1]};
    // Product bits [63:31] live at p_shift[64:32]; all equal means it fits.
    ovf_nxt = !((&p_shift[2*WIDTH:WIDTH]) || !(|p_shift[2*WIDTH:WIDTH]));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      m          <= '0;
      p          <= '0;
      result     <= '0;
      overflow   <= 1'b0;
      result_rdy <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            m     <= {multiplicand[WIDTH-1], multiplicand};
            p     <= {{(WIDTH+1){1'b0}}, multiplier, 1'b0};
            state <= RUN;
          end
        end
        RUN: begin
          p <= p_shift;
          if (count == ITER_LAST) begin
            state      <= DONE;
            result     <= p_shift[WIDTH:1];
            overflow   <= ovf_nxt;
            result_rdy <= 1'b1;
          end
        end
        DONE: begin
          state      <= IDLE;
          result_rdy <= 1'b0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mult_32.sv
// Directed bench for booth_mult_32: hand-computed products, latency, busy
// width, ignored starts, and reset abort.
module tb_booth_mult_32;

  logic        clk;
  logic        rst;
  logic        start;
  logic [31:0] multiplicand;
  logic [31:0] multiplier;
  logic        busy;
  logic        result_rdy;
  logic [31:0] result;
  logic        overflow;

  int n_checks;
  int n_fail;

  booth_mult_32 #(.WIDTH(32)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .multiplicand (multiplicand),
    .multiplier   (multiplier),
    .busy         (busy),
    .result_rdy   (result_rdy),
    .result       (result),
    .overflow     (overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one clock and land 1 time unit after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Launch one operation. start_at: RUN cycle index for a stray start with
  // multiplicand=100 (-1 = none). rst_at: RUN cycle index to reset (-1 = none).
  // lat counts edges from the accept edge to the edge raising result_rdy.
  task automatic run_op(input logic [31:0] m, input logic [31:0] q,
                        input int start_at, input int rst_at,
                        output int lat, output int busy_cnt, output bit got);
    multiplicand = m;
    multiplier   = q;
    start        = 1'b1;
    step();
    start    = 1'b0;
    lat      = 0;
    busy_cnt = 0;
    got      = 1'b0;
    while (!got && lat < 60) begin
      if (busy) busy_cnt++;
      multiplicand = (lat == start_at) ? 32'd100 : m;
      start        = (lat == start_at);
      rst          = (lat == rst_at);
      step();
      lat++;
      start = 1'b0;
      if (rst) begin
        rst = 1'b0;
        return;
      end
      got = result_rdy;
    end
  endtask

  task automatic expect_op(input string tag, input logic [31:0] m, input logic [31:0] q,
                           input logic [31:0] exp_res, input logic exp_ovf);
    int  lat;
    int  bc;
    bit  got;
    run_op(m, q, -1, -1, lat, bc, got);
    check({tag, "_rdy"}, {31'd0, got}, 32'd1);
    check({tag, "_res"}, result, exp_res);
    check({tag, "_ovf"}, {31'd0, overflow}, {31'd0, exp_ovf});
    step();
    check({tag, "_rdy_drop"}, {31'd0, result_rdy}, 32'd0);
    check({tag, "_hold"}, result, exp_res);
  endtask

  initial begin
    int lat;
    int bc;
    bit got;
    int extra;

    n_checks     = 0;
    n_fail       = 0;
    rst          = 1'b1;
    start        = 1'b0;
    multiplicand = '0;
    multiplier   = '0;
    step();
    rst = 1'b0;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_rdy", {31'd0, result_rdy}, 32'd0);
    check("rst_res", result, 32'd0);
    check("rst_ovf", {31'd0, overflow}, 32'd0);

    // Basic latency and busy width.
    run_op(32'd3, 32'd5, -1, -1, lat, bc, got);
    check("basic_rdy", {31'd0, got}, 32'd1);
    check("basic_lat", lat, 32'd32);
    check("basic_busy_cycles", bc, 32'd32);
    check("basic_busy_at_rdy", {31'd0, busy}, 32'd0);
    check("basic_res", result, 32'd15);
    check("basic_ovf", {31'd0, overflow}, 32'd0);
    // Start in the result_rdy cycle must be ignored.
    multiplicand = 32'd7;
    multiplier   = 32'd7;
    start        = 1'b1;
    step();
    start = 1'b0;
    check("start_at_rdy_ignored", {31'd0, busy}, 32'd0);
    check("basic_idle_hold", result, 32'd15);
    step();
    check("basic_still_idle", {31'd0, busy}, 32'd0);

    expect_op("mixed", 32'hFFFF_FFF9, 32'd6, 32'hFFFF_FFD6, 1'b0);
    expect_op("minneg_x_m1", 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b1);
    expect_op("minneg_x_1", 32'h8000_0000, 32'd1, 32'h8000_0000, 1'b0);
    expect_op("ovf_2p32", 32'h0001_0000, 32'h0001_0000, 32'h0000_0000, 1'b1);

    // Stray start during RUN is ignored and not queued.
    run_op(32'd2, 32'd9, 10, -1, lat, bc, got);
    check("ign_rdy", {31'd0, got}, 32'd1);
    check("ign_lat", lat, 32'd32);
    check("ign_res", result, 32'd18);
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (result_rdy) extra++;
    end
    check("ign_no_second_rdy", extra, 32'd0);
    expect_op("fresh", 32'd1000, 32'hFFFF_FC18, 32'hFFF0_BDC0, 1'b0);

    // Reset mid-RUN aborts with no result.
    run_op(32'd5, 32'd5, -1, 12, lat, bc, got);
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_res", result, 32'd0);
    check("abort_ovf", {31'd0, overflow}, 32'd0);
    extra = 0;
    for (int i = 0; i < 40; i++) begin
      if (result_rdy) extra++;
      step();
    end
    check("abort_no_rdy", extra, 32'd0);
    expect_op("after_abort", 32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'd16, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/booth_mult_32.md
Name: booth_mult_32

Overview:
- Sequential signed 32x32 radix-2 Booth multiplier for the multdiv unit.
- It is the consumer of the 5-bit iteration counter `counter_32`. That counter is instantiated inside this block, and its `count` output sequences the 32 Booth iterations.
- It accepts operands on a one-cycle `start` pulse and produces a 32-bit result plus an overflow flag after a fixed latency.
- It sits between the ALU operand latch and the writeback mux.

Parameters:
- WIDTH, 32, operand/result width. Fixed at 32 in this revision because the iteration counter is the 5-bit `counter_32`. Any other value is a lint/elab error.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request; sampled only in IDLE.
- multiplicand  input  32  signed operand M; captured when start is accepted.
- multiplier  input  32  signed operand Q; captured when start is accepted.
- busy  output  1  high while in RUN.
- result_rdy  output  1  one-cycle pulse; result/overflow are valid in that cycle.
- result  output  32  low 32 bits of the signed 64-bit product.
- overflow  output  1  product not representable in 32-bit signed.

Behaviour:
- Reset (rst high at posedge): state=IDLE; busy=0, result_rdy=0, result=0, overflow=0; counter reset to 0. Reset overrides start and any in-flight operation.
- States: IDLE, RUN, DONE.
- IDLE:
  - start=1 at edge k: latch M sign-extended to 33 bits.
  - Load product register P[65:0] = {33'b0, Q, 1'b0}.
  - Pulse the counter's rst so count=0, then enter RUN.
  - start=0: remain in IDLE; outputs hold their last values.
- RUN (edges k+1 .. k+32), counter enabled, one iteration per edge:
  - P[1:0]=01: add M to P[65:33].
  - P[1:0]=10: subtract M from P[65:33].
  - P[1:0]=00 or 11: no add/subtract.
  - Then arithmetic shift right P by 1.
  - Upper accumulator is 33 bits, so M=-2^31 never overflows internally.
  - On the edge where count==31 (32nd iteration), go to DONE.
- DONE (one cycle, entered at edge k+32):
  - result_rdy=1; result=P[32:1].
  - overflow=1 iff product bits [63:31] (P[64:32]) are not all equal.
  - Next edge: go to IDLE, result_rdy=0.
- Latency: start at edge k gives result_rdy high in the cycle following edge k+32. This is 33 cycles start-to-result; throughput is one operation per 34 cycles.
- Output hold: result and overflow are registered at DONE and hold until the next DONE or reset.
- busy is 1 exactly in RUN (32 cycles).
- start during RUN or DONE is ignored, not queued.
- start in the same cycle as the result_rdy pulse is ignored. The earliest accepted start is the cycle after result_rdy.
- Counter wrap: count wraps 31->0 at the final iteration. This is harmless because the FSM leaves RUN on that same edge.
- Counter enable is deasserted outside RUN.
- rst mid-RUN: next cycle is IDLE with all outputs 0. No result_rdy is produced for the aborted operation.
- Operands may change after acceptance without effect.

Decomposition:
- Shared multdiv package: state encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the constant ITER_LAST=5'd31. The future divider reuses these.
- Sub-module: the existing `counter_32` (clk, en, rst, count[4:0]) as the iteration counter.
  - Its rst is driven by rst OR accept-start.
  - Its en is driven by (state==RUN).
- The add/subtract datapath stays inline.

Test Plan:
- Basic latency: rst 1 cycle; M=3, Q=5, start pulse -> busy high for exactly 32 cycles; result_rdy pulse 33 cycles after start; result=15, overflow=0; then idle.
- Mixed sign: M=-7 (0xFFFFFFF9), Q=6 -> result=0xFFFFFFD6 (-42), overflow=0.
- Corner case: M=0x80000000, Q=0xFFFFFFFF -> result=0x80000000, overflow=1.
- Second corner case: M=0x80000000, Q=1 -> result=0x80000000, overflow=0.
- Overflow: M=0x00010000, Q=0x00010000 -> result=0x00000000, overflow=1.
- Ignored start: with M=2, Q=9, pulse start again at RUN cycle 10 with M=100 -> first result=18 at the original cycle; no second result_rdy. A fresh start after result_rdy yields a correct new result.
- Reset mid-operation: assert rst at RUN cycle 12 -> next cycle busy=0, result=0, result_rdy never pulses. A new start M=-4, Q=-4 -> result=16 after 33 cycles.
